// File: rtl/fetch_decode_pipe.sv
// Pipeline front end: fetch PC register plus the F/D and D/X instruction latches.
// Applies one of hold / flush / bubble / advance per clock and counts bubbles and flushes.
module fetch_decode_pipe #(
  parameter int                     PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC  = '0,
  parameter int                     CNT_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           imem_q,
  input  logic                  stall,
  input  logic                  md_busy,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [PC_WIDTH-1:0]   pcFD,
  output logic [31:0]           instFD,
  output logic [PC_WIDTH-1:0]   pcDX,
  output logic [31:0]           instDX,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  flush_cnt
);

  // Handshake: stall, redirect and md_busy are level signals sampled only at the
  // rising edge; there is no ready/acknowledge path back to the producers.
  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_FLUSH   = 2'd2,
    ACT_HOLD    = 2'd3
  } act_t;

  act_t                 act;
  logic [PC_WIDTH-1:0]  pc_inc;
  logic                 stall_sat;
  logic                 flush_sat;

  // md_busy freezes X, so a redirect seen during a hold reappears afterwards.
  always_comb begin
    act = ACT_ADVANCE;
    if (md_busy)       act = ACT_HOLD;
    else if (redirect) act = ACT_FLUSH;
    else if (stall)    act = ACT_BUBBLE;
  end

  assign pc_inc    = pc + PC_WIDTH'(1);
  assign stall_sat = &stall_cnt;
  assign flush_sat = &flush_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc     <= RESET_PC;
      pcFD   <= '0;
      instFD <= '0;
      pcDX   <= '0;
      instDX <= '0;
    end else begin
      case (act)
        ACT_FLUSH: begin
          pc     <= redirect_pc;
          pcFD   <= '0;
          instFD <= '0;
          pcDX   <= '0;
          instDX <= '0;
        end
        ACT_BUBBLE: begin
          pcDX   <= '0;
          instDX <= '0;
        end
        ACT_ADVANCE: begin
          pc     <= pc_inc;
          pcFD   <= pc_inc;
          instFD <= imem_q;
          pcDX   <= pcFD;
          instDX <= instFD;
        end
        default: begin
          pc     <= pc;
          pcFD   <= pcFD;
          instFD <= instFD;
          pcDX   <= pcDX;
          instDX <= instDX;
        end
      endcase
    end
  end

  // Performance counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (act == ACT_BUBBLE && !stall_sat) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (act == ACT_FLUSH && !flush_sat)  flush_cnt <= flush_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Self-checking bench for fetch_decode_pipe: directed scenarios then randomized
// traffic, all compared against a behavioural model of the front end.
module tb_fetch_decode_pipe;

  localparam int PW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   imem_q;
  logic          stall;
  logic          md_busy;
  logic          redirect;
  logic [PW-1:0] redirect_pc;
  logic [PW-1:0] pc, pcFD, pcDX;
  logic [31:0]   instFD, instDX;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  // behavioural model state
  logic [31:0] m_pc, m_pcfd, m_instfd, m_pcdx, m_instdx;
  int          m_scnt, m_fcnt;

  fetch_decode_pipe #(.PC_WIDTH(PW), .RESET_PC('0), .CNT_WIDTH(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_q      (imem_q),
    .stall       (stall),
    .md_busy     (md_busy),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .pcFD        (pcFD),
    .instFD      (instFD),
    .pcDX        (pcDX),
    .instDX      (instDX),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  // clock / reset block
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_pcfd = '0; m_instfd = '0; m_pcdx = '0; m_instdx = '0;
    m_scnt = 0; m_fcnt = 0;
  endtask

  // One clock edge of the front end, written from the priority rules.
  task automatic model_edge();
    if (md_busy) begin
      // everything frozen
    end else if (redirect) begin
      m_pc = redirect_pc;
      m_pcfd = 0; m_instfd = 0; m_pcdx = 0; m_instdx = 0;
      m_fcnt = (m_fcnt < CMAX) ? m_fcnt + 1 : CMAX;
    end else if (stall) begin
      m_pcdx = 0; m_instdx = 0;
      m_scnt = (m_scnt < CMAX) ? m_scnt + 1 : CMAX;
    end else begin
      m_pcdx   = m_pcfd;
      m_instdx = m_instfd;
      m_instfd = imem_q;
      m_pc     = m_pc + 32'd1;
      m_pcfd   = m_pc;
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".pc"},        pc,                m_pc);
    check_eq({tag, ".pcFD"},      pcFD,              m_pcfd);
    check_eq({tag, ".instFD"},    instFD,            m_instfd);
    check_eq({tag, ".pcDX"},      pcDX,              m_pcdx);
    check_eq({tag, ".instDX"},    instDX,            m_instdx);
    check_eq({tag, ".stall_cnt"}, 32'(stall_cnt),    32'(m_scnt));
    check_eq({tag, ".flush_cnt"}, 32'(flush_cnt),    32'(m_fcnt));
  endtask

  // driver: apply inputs, take one edge, update the model, compare
  task automatic step(input string tag, input logic s, input logic r,
                      input logic [31:0] rpc, input logic b, input logic [31:0] q);
    stall = s; redirect = r; redirect_pc = rpc; md_busy = b; imem_q = q;
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] snap_pc, snap_fd, snap_dx;
    int          snap_s, snap_f;

    reset = 1'b1; stall = 0; redirect = 0; redirect_pc = '0; md_busy = 0; imem_q = '0;
    model_reset();
    #12;
    check_all("reset");
    reset = 1'b0;

    // basic fetch
    for (int i = 0; i < 4; i++) step("adv", 0, 0, '0, 0, 32'h0800_0001 + 32'(i));
    check_eq("dir.pc",     pc,     32'd4);
    check_eq("dir.instFD", instFD, 32'h0800_0004);
    check_eq("dir.pcFD",   pcFD,   32'd4);
    check_eq("dir.instDX", instDX, 32'h0800_0003);
    check_eq("dir.pcDX",   pcDX,   32'd3);

    // two-cycle load-use stall
    step("stall1", 1, 0, '0, 0, 32'h0800_0005);
    check_eq("stall1.instDX", instDX, 32'h0);
    step("stall2", 1, 0, '0, 0, 32'h0800_0005);
    check_eq("stall2.pc",        pc,                32'd4);
    check_eq("stall2.instFD",    instFD,            32'h0800_0004);
    check_eq("stall2.stall_cnt", 32'(stall_cnt),    32'd2);
    step("release", 0, 0, '0, 0, 32'h0800_0005);
    check_eq("release.instDX", instDX, 32'h0800_0004);

    // redirect wins over a simultaneous stall
    step("flush", 1, 1, 32'h40, 0, 32'hdead_beef);
    check_eq("flush.pc",        pc,             32'h40);
    check_eq("flush.instFD",    instFD,         32'h0);
    check_eq("flush.instDX",    instDX,         32'h0);
    check_eq("flush.flush_cnt", 32'(flush_cnt), 32'd1);
    check_eq("flush.stall_cnt", 32'(stall_cnt), 32'd2);
    step("after_flush", 0, 0, '0, 0, 32'h0000_1234);
    check_eq("after_flush.pcFD", pcFD, 32'h41);

    // md_busy holds everything for 3 cycles
    snap_pc = m_pc; snap_fd = m_instfd; snap_dx = m_instdx; snap_s = m_scnt; snap_f = m_fcnt;
    for (int i = 0; i < 3; i++) begin
      step("hold", 1'(i[0]), 1'(~i[0]), 32'h99, 1, $urandom);
      check_eq("hold.pc",     pc,             snap_pc);
      check_eq("hold.instFD", instFD,         snap_fd);
      check_eq("hold.instDX", instDX,         snap_dx);
      check_eq("hold.scnt",   32'(stall_cnt), 32'(snap_s));
      check_eq("hold.fcnt",   32'(flush_cnt), 32'(snap_f));
    end

    // PC wrap
    step("wrap_redir", 0, 1, 32'hFFFF_FFFF, 0, 32'h0);
    step("wrap_adv",   0, 0, '0, 0, 32'h0000_0777);
    check_eq("wrap.pc",   pc,   32'h0);
    check_eq("wrap.pcFD", pcFD, 32'h0);

    // counter saturation
    for (int i = 0; i < CMAX + 2; i++) step("sat_stall", 1, 0, '0, 0, $urandom);
    check_eq("sat.stall_cnt", 32'(stall_cnt), 32'(CMAX));
    for (int i = 0; i < CMAX + 2; i++) step("sat_flush", 0, 1, $urandom, 0, $urandom);
    check_eq("sat.flush_cnt", 32'(flush_cnt), 32'(CMAX));

    // randomized traffic after a fresh reset
    reset = 1'b1; #1; reset = 1'b0; model_reset();
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 99) < 20),
           ($urandom_range(0, 99) < 8),
           $urandom,
           ($urandom_range(0, 99) < 10),
           $urandom);
    end

    // asynchronous reset mid-cycle during a stall
    step("pre_areset", 0, 0, '0, 0, 32'h0800_00AA);
    step("pre_areset", 0, 0, '0, 0, 32'h0800_00BB);
    step("areset_stall", 1, 0, '0, 0, 32'h0800_00CC);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_eq("areset.pc",     pc,             32'h0);
    check_eq("areset.instFD", instFD,         32'h0);
    check_eq("areset.instDX", instDX,         32'h0);
    check_eq("areset.pcDX",   pcDX,           32'h0);
    check_eq("areset.scnt",   32'(stall_cnt), 32'h0);
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) step("post_areset", 0, 0, '0, 0, 32'h0800_0100 + 32'(i));
    check_eq("post_areset.instDX", instDX, 32'h0800_0101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
